// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    // Instruction address bus width.
    localparam int INST_ADDR_W = 32;

    // Bit positions inside the stall vector.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Stall patterns. A requester freezes its own stage and every earlier stage.
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_IF_PAT  = 6'b000011;
    localparam logic [5:0] STALL_ID_PAT  = 6'b000111;
    localparam logic [5:0] STALL_EX_PAT  = 6'b001111;
    localparam logic [5:0] STALL_MEM_PAT = 6'b011111;

    // Redirect FSM states.
    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_DRAIN = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_prio_enc.sv
// Combinational priority encoder: highest pipeline requester wins the stall vector.
module pipeline_ctrl_stall_prio_enc
    import pipeline_ctrl_pkg::*;
(
    input  logic       req_if,
    input  logic       req_id,
    input  logic       req_ex,
    input  logic       req_mem,
    input  logic       id_mask,
    output logic [5:0] stall
);

    // Later stages take priority; an ID request is ignored while ID is being flushed.
    always_comb begin
        stall = STALL_NONE;
        if (req_mem) begin
            stall = STALL_MEM_PAT;
        end else if (req_ex) begin
            stall = STALL_EX_PAT;
        end else if (req_id && !id_mask) begin
            stall = STALL_ID_PAT;
        end else if (req_if) begin
            stall = STALL_IF_PAT;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: stall vector encoding, branch flush/redirect FSM
// (redirects deferred while a fetch is in flight) and a sticky stall watchdog.
// Optional: define PIPELINE_CTRL_PERF_EN to add stall-cycle and flush-event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1023,
    parameter int TO_W          = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   ex_branch_flag,
    input  logic [INST_ADDR_W-1:0] ex_branch_target,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic                   pc_redirect,
    output logic [INST_ADDR_W-1:0] new_pc,
    output logic                   fetch_discard,
    output logic                   stall_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(STALL_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};

    ctrl_state_e            state_q, state_d;
    logic [INST_ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   stall_timeout_q, stall_timeout_d;
    logic                   run_branch;
    logic                   ex_adv;
    logic                   req_en;

    // EX advances unless EX/MEM is held; derived from the requests directly so the
    // flush -> id-mask -> stall path stays acyclic.
    assign ex_adv = !(stallreq_mem || stallreq_ex);
    assign req_en = !rst;

    pipeline_ctrl_stall_prio_enc u_prio_enc (
        .req_if  (stallreq_if  && req_en),
        .req_id  (stallreq_id  && req_en),
        .req_ex  (stallreq_ex  && req_en),
        .req_mem (stallreq_mem && req_en),
        .id_mask (flush),
        .stall   (stall)
    );

    // Redirect FSM: immediate redirect in RUN, or drain the in-flight fetch first.
    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        flush         = 1'b0;
        pc_redirect   = 1'b0;
        new_pc        = '0;
        fetch_discard = 1'b0;
        run_branch    = 1'b0;
        case (state_q)
            CTRL_RUN: begin
                if (ex_branch_flag && ex_adv) begin
                    flush      = 1'b1;
                    run_branch = 1'b1;
                    if (!stallreq_if) begin
                        pc_redirect = 1'b1;
                        new_pc      = ex_branch_target;
                    end else begin
                        pend_pc_d = ex_branch_target;
                        state_d   = CTRL_DRAIN;
                    end
                end
            end
            CTRL_DRAIN: begin
                flush         = 1'b1;
                fetch_discard = 1'b1;
                if (!stallreq_if) begin
                    pc_redirect = 1'b1;
                    new_pc      = pend_pc_q;
                    state_d     = CTRL_RUN;
                end
            end
            default: state_d = CTRL_RUN;
        endcase
        // Reset gates every output and abandons any pending redirect.
        if (rst) begin
            flush         = 1'b0;
            pc_redirect   = 1'b0;
            new_pc        = '0;
            fetch_discard = 1'b0;
            run_branch    = 1'b0;
            state_d       = CTRL_RUN;
            pend_pc_d     = '0;
        end
    end

    // Watchdog: saturating count of consecutive PC-stall cycles, sticky error flag.
    always_comb begin
        to_cnt_d = '0;
        if (stall[STALL_PC]) begin
            to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        end
        stall_timeout_d = stall_timeout_q || (to_cnt_d >= TO_LIMIT);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= CTRL_RUN;
            pend_pc_q       <= '0;
            to_cnt_q        <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_pc_q       <= pend_pc_d;
            to_cnt_q        <= to_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Saturating performance counters.
    always_comb begin
        perf_stall_cycles_d = perf_stall_cycles_q;
        perf_flush_cnt_d    = perf_flush_cnt_q;
        if (stall[STALL_PC] && perf_stall_cycles_q != 32'hFFFF_FFFF) begin
            perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
        end
        if (run_branch && perf_flush_cnt_q != 32'hFFFF_FFFF) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles_q <= '0;
            perf_flush_cnt_q    <= '0;
        end else begin
            perf_stall_cycles_q <= perf_stall_cycles_d;
            perf_flush_cnt_q    <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_q;
    assign perf_flush_cnt    = perf_flush_cnt_q;
`else
    logic unused_run_branch;
    assign unused_run_branch = run_branch;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed vector table, then randomized stimulus
// checked against a behavioural model of the stall/flush/redirect rules.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        ex_branch_flag;
    logic [31:0] ex_branch_target;
    logic [5:0]  stall;
    logic        flush, pc_redirect, fetch_discard, stall_timeout;
    logic [31:0] new_pc;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

    pipeline_ctrl #(.STALL_TIMEOUT(TO), .TO_W(TW)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_if      (stallreq_if),
        .stallreq_id      (stallreq_id),
        .stallreq_ex      (stallreq_ex),
        .stallreq_mem     (stallreq_mem),
        .ex_branch_flag   (ex_branch_flag),
        .ex_branch_target (ex_branch_target),
        .stall            (stall),
        .flush            (flush),
        .pc_redirect      (pc_redirect),
        .new_pc           (new_pc),
        .fetch_discard    (fetch_discard),
        .stall_timeout    (stall_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        rst, rif, rid, rex, rmem, br;
        logic [31:0] tgt;
        logic [5:0]  e_stall;
        logic        e_flush, e_redir;
        logic [31:0] e_pc;
        logic        e_disc, e_to;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic r, input logic i, input logic d, input logic e,
                        input logic m, input logic b, input logic [31:0] t,
                        input logic [5:0] es, input logic ef, input logic er,
                        input logic [31:0] ep, input logic ed, input logic et);
        vec_t v;
        v.rst = r; v.rif = i; v.rid = d; v.rex = e; v.rmem = m; v.br = b; v.tgt = t;
        v.e_stall = es; v.e_flush = ef; v.e_redir = er; v.e_pc = ep;
        v.e_disc = ed; v.e_to = et;
        vt.push_back(v);
    endtask

    task automatic drive(input logic r, input logic i, input logic d, input logic e,
                         input logic m, input logic b, input logic [31:0] t);
        rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = e;
        stallreq_mem = m; ex_branch_flag = b; ex_branch_target = t;
    endtask

    // Behavioural model state
    bit          m_drain;
    logic [31:0] m_pend;
    int          m_cnt;
    bit          m_to;
    longint      m_perf_stall, m_perf_flush;

    initial begin
        //      rst if id ex mem br tgt           stall     fl rd pc           ds to
        // request encoding
        addv(0, 0, 1, 0, 0, 0, 32'h0,       6'b000111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 1, 0, 1, 0, 32'h0,       6'b011111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        // immediate redirect
        addv(0, 0, 0, 0, 0, 1, 32'h100,     6'b000000, 1, 1, 32'h100,     0, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        // deferred redirect; 4 PC-stall cycles trip the watchdog on the way
        addv(0, 1, 0, 0, 0, 1, 32'h200,     6'b000011, 1, 0, 32'h0,       0, 0);
        addv(0, 1, 0, 0, 0, 1, 32'h999,     6'b000011, 1, 0, 32'h0,       1, 0);
        addv(0, 1, 0, 0, 0, 0, 32'h0,       6'b000011, 1, 0, 32'h0,       1, 0);
        addv(0, 1, 1, 0, 0, 0, 32'h0,       6'b000011, 1, 0, 32'h0,       1, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 1, 1, 32'h200,     1, 1);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
        addv(1, 0, 1, 0, 1, 1, 32'h55,      6'b000000, 0, 0, 32'h0,       0, 1);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        // branch held behind a MEM stall
        addv(0, 0, 0, 0, 1, 1, 32'h300,     6'b011111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 0, 1, 1, 32'h300,     6'b011111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 0, 0, 1, 32'h300,     6'b000000, 1, 1, 32'h300,     0, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        // ID request masked by flush
        addv(0, 0, 1, 0, 0, 1, 32'h40,      6'b000000, 1, 1, 32'h40,      0, 0);
        // reset in DRAIN abandons redirect
        addv(0, 1, 0, 0, 0, 1, 32'h500,     6'b000011, 1, 0, 32'h0,       0, 0);
        addv(0, 1, 0, 0, 0, 0, 32'h0,       6'b000011, 1, 0, 32'h0,       1, 0);
        addv(1, 1, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        addv(0, 1, 0, 0, 0, 0, 32'h0,       6'b000011, 0, 0, 32'h0,       0, 0);
        // branch while the fetch completes this cycle takes the immediate path
        addv(0, 0, 0, 0, 0, 1, 32'h600,     6'b000000, 1, 1, 32'h600,     0, 0);
        // watchdog via EX stall
        addv(0, 0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
        addv(1, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
        // MEM stall during DRAIN, redirect when the fetch lands
        addv(0, 1, 0, 0, 0, 1, 32'h700,     6'b000011, 1, 0, 32'h0,       0, 0);
        addv(0, 1, 0, 0, 1, 0, 32'h0,       6'b011111, 1, 0, 32'h0,       1, 0);
        addv(0, 0, 0, 0, 1, 0, 32'h0,       6'b011111, 1, 1, 32'h700,     1, 0);
        addv(0, 0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);

        drive(1, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].rif, vt[i].rid, vt[i].rex, vt[i].rmem, vt[i].br, vt[i].tgt);
            @(negedge clk);
            chk($sformatf("row%0d stall", i),    {26'b0, stall},          {26'b0, vt[i].e_stall});
            chk($sformatf("row%0d flush", i),    {31'b0, flush},          {31'b0, vt[i].e_flush});
            chk($sformatf("row%0d redirect", i), {31'b0, pc_redirect},    {31'b0, vt[i].e_redir});
            chk($sformatf("row%0d new_pc", i),   new_pc,                  vt[i].e_pc);
            chk($sformatf("row%0d discard", i),  {31'b0, fetch_discard},  {31'b0, vt[i].e_disc});
            chk($sformatf("row%0d timeout", i),  {31'b0, stall_timeout},  {31'b0, vt[i].e_to});
            $display("row %0d: rst=%0b if=%0b id=%0b ex=%0b mem=%0b br=%0b stall=%b flush=%0b redir=%0b pc=%0h",
                     i, vt[i].rst, vt[i].rif, vt[i].rid, vt[i].rex, vt[i].rmem, vt[i].br,
                     stall, flush, pc_redirect, new_pc);
            @(posedge clk);
            #1;
        end

        // Randomized phase against the behavioural model
        m_drain = 0; m_pend = 0; m_cnt = 0; m_to = 0; m_perf_stall = 0; m_perf_flush = 0;
        for (int c = 0; c < 600; c++) begin
            logic        r, i_, d, e, m, b;
            logic [31:0] t;
            bit          adv, fl, rd, ds, branch_evt;
            int          lvl;
            logic [5:0]  es;
            logic [31:0] ep;
            r  = (c == 0) || ($urandom_range(0, 49) == 0);
            i_ = ($urandom_range(0, 9) < 3);
            d  = ($urandom_range(0, 9) < 2);
            e  = ($urandom_range(0, 9) < 1);
            m  = ($urandom_range(0, 19) < 3);
            b  = ($urandom_range(0, 9) < 3);
            t  = $urandom;
            drive(r, i_, d, e, m, b, t);

            adv        = !(m || e);
            branch_evt = !r && !m_drain && b && adv;
            fl         = !r && (m_drain || branch_evt);
            rd         = !r && (m_drain ? !i_ : (branch_evt && !i_));
            ds         = !r && m_drain;
            ep         = rd ? (m_drain ? m_pend : t) : 32'h0;
            if (r)               lvl = 0;
            else if (m)          lvl = 5;
            else if (e)          lvl = 4;
            else if (d && !fl)   lvl = 3;
            else if (i_)         lvl = 2;
            else                 lvl = 0;
            es = 6'((1 << lvl) - 1);

            @(negedge clk);
            chk($sformatf("rnd%0d stall", c),    {26'b0, stall},         {26'b0, es});
            chk($sformatf("rnd%0d flush", c),    {31'b0, flush},         {31'b0, fl});
            chk($sformatf("rnd%0d redirect", c), {31'b0, pc_redirect},   {31'b0, rd});
            chk($sformatf("rnd%0d new_pc", c),   new_pc,                 ep);
            chk($sformatf("rnd%0d discard", c),  {31'b0, fetch_discard}, {31'b0, ds});
            if (c > 0) chk($sformatf("rnd%0d timeout", c), {31'b0, stall_timeout}, {31'b0, m_to});
`ifdef PIPELINE_CTRL_PERF_EN
            if (c > 0) begin
                chk($sformatf("rnd%0d perf_stall", c), perf_stall_cycles, 32'(m_perf_stall));
                chk($sformatf("rnd%0d perf_flush", c), perf_flush_cnt,    32'(m_perf_flush));
            end
`endif
            $display("rnd %0d: rst=%0b req(if,id,ex,mem)=%0b%0b%0b%0b br=%0b stall=%b flush=%0b redir=%0b pc=%0h to=%0b",
                     c, r, i_, d, e, m, b, stall, flush, pc_redirect, new_pc, stall_timeout);

            // model state update for the coming edge
            if (r) begin
                m_drain = 0; m_pend = 0; m_cnt = 0; m_to = 0;
                m_perf_stall = 0; m_perf_flush = 0;
            end else begin
                if (es[0]) begin
                    m_cnt = (m_cnt + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : m_cnt + 1;
                    m_perf_stall++;
                end else begin
                    m_cnt = 0;
                end
                if (m_cnt >= TO) m_to = 1;
                if (branch_evt) m_perf_flush++;
                if (m_drain) begin
                    if (!i_) m_drain = 0;
                end else if (branch_evt && i_) begin
                    m_drain = 1;
                    m_pend  = t;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
